// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 RAM arbiter slice.
// Requester indices, owner encoding and parameter defaults.
package chip8_pkg;

  localparam int AW_DEF       = 12;
  localparam int DW_DEF       = 8;
  localparam int MAX_LOCK_DEF = 16;

  localparam int REQ_LOADER = 0;
  localparam int REQ_CPU    = 1;
  localparam int REQ_SPRITE = 2;

  typedef enum logic [1:0] {
    OWN_R0   = 2'b00,
    OWN_R1   = 2'b01,
    OWN_R2   = 2'b10,
    OWN_NONE = 2'b11
  } owner_e;

endpackage

// File: rtl/chip8_rr_pick2.sv
// Two-way round-robin picker between CPU (R1) and sprite engine (R2).
// rr_last=1 means R2 won last, so R1 is favoured on contention.
module chip8_rr_pick2 (
  input  logic       req1,
  input  logic       req2,
  input  logic       rr_last,
  output logic [1:0] pick
);

  always_comb begin
    pick    = 2'b00;
    pick[0] = req1 & (~req2 | rr_last);
    pick[1] = req2 & (~req1 | ~rr_last);
  end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Single-port CHIP-8 RAM arbiter: loader priority, CPU/sprite
// round-robin, lockable ownership with a fairness beat limit.
module chip8_mem_arbiter
  import chip8_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    req,
  input  logic [2:0]    we,
  input  logic [2:0]    lock,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  output logic [2:0]    gnt,
  output logic [2:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  owner_e        owner_q, owner_d;
  logic          rr_last_q, rr_last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [2:0]    rvalid_q, rvalid_d;
  logic          busy_q, busy_d;
  logic [1:0]    pick;
  logic          acc_lock;

  chip8_rr_pick2 u_pick (
    .req1    (req[REQ_CPU]),
    .req2    (req[REQ_SPRITE]),
    .rr_last (rr_last_q),
    .pick    (pick)
  );

  always_comb begin
    gnt = 3'b000;
    if (!reset) begin
      unique case (owner_q)
        OWN_NONE: gnt = req[0] ? 3'b001 : {pick, 1'b0};
        OWN_R0:   gnt[0] = req[0];
        OWN_R1:   gnt[1] = req[1];
        OWN_R2:   gnt[2] = req[2];
        default:  gnt = 3'b000;
      endcase
    end
  end

  always_comb begin
    mem_en    = |gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      gnt[0]: begin
        mem_we    = we[0];
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      gnt[1]: begin
        mem_we    = we[1];
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      gnt[2]: begin
        mem_we    = we[2];
        mem_addr  = addr2;
        mem_wdata = wdata2;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    cnt_inc   = cnt_q + CW'(1);
    acc_lock  = |(gnt & lock);
    if (gnt[0]) begin
      // The loader may hold the RAM indefinitely; it is never counted.
      owner_d = acc_lock ? OWN_R0 : OWN_NONE;
      cnt_d   = '0;
    end else if (|gnt) begin
      if (acc_lock && cnt_inc < CW'(MAX_LOCK)) begin
        owner_d = gnt[2] ? OWN_R2 : OWN_R1;
        cnt_d   = cnt_inc;
      end else begin
        owner_d   = OWN_NONE;
        cnt_d     = '0;
        rr_last_d = gnt[2];
      end
    end else if (owner_q != OWN_NONE) begin
      owner_d = OWN_NONE;
      cnt_d   = '0;
      if (owner_q != OWN_R0) rr_last_d = (owner_q == OWN_R2);
    end
    rvalid_d = gnt & ~we;
    busy_d   = (owner_d != OWN_NONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= OWN_NONE;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
      rvalid_q  <= 3'b000;
      busy_q    <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      busy_q    <= busy_d;
    end
  end

  assign rvalid = rvalid_q;
  assign busy   = busy_q;
  assign rdata  = mem_rdata;

endmodule
